// File: rtl/ncc_ctrl.sv
// Pass sequencer for the NCC PE array: descriptor load, window streaming, result tagging.
// Optional NCC_CTRL_DESC_RELOAD_EN lets a pass reuse the previously loaded descriptor.
module ncc_ctrl #(
  parameter int unsigned ROWS       = 16,
  parameter int unsigned COL_GROUPS = 4,
  parameter int unsigned WIN_COLS   = 40,
  parameter int unsigned ACC_LAT    = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        keep_desc,
  input  logic                        desc_valid,
  output logic                        desc_ready,
  input  logic                        win_valid,
  output logic                        win_ready,
  output logic                        load_desc_now,
  output logic [ROWS-1:0]             load_row,
  output logic [COL_GROUPS-1:0]       load_col_group,
  output logic                        load_win_reg,
  output logic                        load_acc_sum_reg,
  output logic                        result_valid,
  output logic [$clog2(WIN_COLS)-1:0] result_idx,
  output logic                        busy,
  output logic                        done
);

  localparam int unsigned IDX_W = $clog2(WIN_COLS);
  localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned GRP_W = (COL_GROUPS > 1) ? $clog2(COL_GROUPS) : 1;
  localparam int unsigned DRN_W = (ACC_LAT > 1) ? $clog2(ACC_LAT) : 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DESC_LOAD = 3'd1,
    WIN_RUN   = 3'd2,
    DRAIN     = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [ROW_W-1:0]   row_cnt;
  logic [GRP_W-1:0]   grp_cnt;
  logic [IDX_W-1:0]   beat_cnt;
  logic [DRN_W-1:0]   drain_cnt;
  logic               desc_loaded;
  logic               reload_ok;
  logic               last_word;
  logic               last_beat;
  logic               qual;
  logic [IDX_W-1:0]   qual_idx;
  logic               vld_sr [ACC_LAT];
  logic [IDX_W-1:0]   idx_sr [ACC_LAT];

`ifdef NCC_CTRL_DESC_RELOAD_EN
  assign reload_ok = keep_desc & desc_loaded;
`else
  logic unused_reload;
  assign unused_reload = keep_desc & desc_loaded;
  assign reload_ok     = 1'b0;
`endif

  assign last_word = (row_cnt == ROW_W'(ROWS - 1)) && (grp_cnt == GRP_W'(COL_GROUPS - 1));
  assign last_beat = (beat_cnt == IDX_W'(WIN_COLS - 1));
  assign qual      = load_win_reg && (beat_cnt >= IDX_W'(ROWS - 1));
  assign qual_idx  = qual ? IDX_W'(beat_cnt - IDX_W'(ROWS - 1)) : '0;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and decoded array strobes
  always_comb begin
    state_nxt        = state;
    desc_ready       = 1'b0;
    win_ready        = 1'b0;
    load_desc_now    = 1'b0;
    load_row         = '0;
    load_col_group   = '0;
    load_win_reg     = 1'b0;
    load_acc_sum_reg = 1'b0;
    done             = 1'b0;
    busy             = (state != IDLE);
    result_valid     = vld_sr[ACC_LAT-1];
    result_idx       = idx_sr[ACC_LAT-1];
    case (state)
      IDLE: begin
        if (start) state_nxt = reload_ok ? WIN_RUN : DESC_LOAD;
      end
      DESC_LOAD: begin
        desc_ready     = 1'b1;
        load_desc_now  = desc_valid;
        load_row       = ROWS'(1) << row_cnt;
        load_col_group = COL_GROUPS'(1) << grp_cnt;
        if (desc_valid && last_word) state_nxt = WIN_RUN;
      end
      WIN_RUN: begin
        win_ready        = 1'b1;
        load_win_reg     = win_valid;
        load_acc_sum_reg = 1'b1;
        if (win_valid && last_beat) state_nxt = DRAIN;
      end
      DRAIN: begin
        load_acc_sum_reg = 1'b1;
        if (drain_cnt == DRN_W'(ACC_LAT - 1)) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Descriptor word counter (row, column group), cleared on entry to DESC_LOAD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_cnt <= '0;
      grp_cnt <= '0;
    end else if (state == IDLE && state_nxt == DESC_LOAD) begin
      row_cnt <= '0;
      grp_cnt <= '0;
    end else if (load_desc_now) begin
      if (grp_cnt == GRP_W'(COL_GROUPS - 1)) begin
        grp_cnt <= '0;
        row_cnt <= last_word ? '0 : ROW_W'(row_cnt + 1'b1);
      end else begin
        grp_cnt <= GRP_W'(grp_cnt + 1'b1);
      end
    end
  end

  // Beat and drain counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt  <= '0;
      drain_cnt <= '0;
    end else begin
      if (state != WIN_RUN && state_nxt == WIN_RUN) beat_cnt <= '0;
      else if (load_win_reg)                        beat_cnt <= IDX_W'(beat_cnt + 1'b1);
      if (state != DRAIN) drain_cnt <= '0;
      else                drain_cnt <= DRN_W'(drain_cnt + 1'b1);
    end
  end

  // Descriptor-loaded flag survives passes; only reset clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         desc_loaded <= 1'b0;
    else if (load_desc_now && last_word) desc_loaded <= 1'b1;
  end

  // Result valid/index pipeline matching the array accumulator latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ACC_LAT; i++) begin
        vld_sr[i] <= 1'b0;
        idx_sr[i] <= '0;
      end
    end else if (load_acc_sum_reg) begin
      for (int i = 1; i < ACC_LAT; i++) begin
        vld_sr[i] <= vld_sr[i-1];
        idx_sr[i] <= idx_sr[i-1];
      end
      vld_sr[0] <= qual;
      idx_sr[0] <= qual_idx;
    end
  end

endmodule

// File: tb/tb_ncc_ctrl.sv
// Directed bench for ncc_ctrl: full passes with per-cycle expected strobes derived from cycle numbers.
module tb_ncc_ctrl;

`ifdef NCC_CTRL_DESC_RELOAD_EN
  localparam bit RELOAD = 1'b1;
`else
  localparam bit RELOAD = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        keep_desc;
  logic        desc_valid;
  logic        desc_ready;
  logic        win_valid;
  logic        win_ready;
  logic        load_desc_now;
  logic [15:0] load_row;
  logic [3:0]  load_col_group;
  logic        load_win_reg;
  logic        load_acc_sum_reg;
  logic        result_valid;
  logic [5:0]  result_idx;
  logic        busy;
  logic        done;

  int total;
  int bad;

  ncc_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .keep_desc        (keep_desc),
    .desc_valid       (desc_valid),
    .desc_ready       (desc_ready),
    .win_valid        (win_valid),
    .win_ready        (win_ready),
    .load_desc_now    (load_desc_now),
    .load_row         (load_row),
    .load_col_group   (load_col_group),
    .load_win_reg     (load_win_reg),
    .load_acc_sum_reg (load_acc_sum_reg),
    .result_valid     (result_valid),
    .result_idx       (result_idx),
    .busy             (busy),
    .done             (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " desc_ready"}, 32'(desc_ready), 0);
    chk({tag, " win_ready"}, 32'(win_ready), 0);
    chk({tag, " load_row"}, 32'(load_row), 0);
    chk({tag, " load_col_group"}, 32'(load_col_group), 0);
    chk({tag, " load_desc_now"}, 32'(load_desc_now), 0);
    chk({tag, " load_acc"}, 32'(load_acc_sum_reg), 0);
    chk({tag, " result_valid"}, 32'(result_valid), 0);
    chk({tag, " result_idx"}, 32'(result_idx), 0);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " done"}, 32'(done), 0);
  endtask

  // One pass; cycle 0 is the cycle in which start is driven high.
  task automatic do_pass(input string name, input bit keep, input bit exp_load,
                         input int stall_k, input int stall_len,
                         input int poke_at, input int abort_at);
    int w;
    int nres;
    bit dr;
    bit wr;
    bit rv;
    w    = exp_load ? 65 + stall_len : 1;
    nres = 0;
    start      = 1'b1;
    keep_desc  = keep;
    desc_valid = 1'b1;
    win_valid  = 1'b0;
    for (int c = 1; c <= w + 57; c++) begin
      @(posedge clk);
      #1;
      start      = (c == poke_at);
      desc_valid = !(stall_len > 0 && c > stall_k && c <= stall_k + stall_len);
      win_valid  = (c >= w && c < w + 40);
      if (c == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk_quiet($sformatf("%s rst@%0d", name, c));
        rst_n      = 1'b1;
        start      = 1'b0;
        desc_valid = 1'b0;
        win_valid  = 1'b0;
        return;
      end
      #1;
      dr = exp_load && (c < w);
      wr = (c >= w) && (c < w + 40);
      rv = (c >= w + 31) && (c <= w + 55);
      chk($sformatf("%s c%0d desc_ready", name, c), 32'(desc_ready), 32'(dr));
      chk($sformatf("%s c%0d load_desc_now", name, c), 32'(load_desc_now), 32'(dr && desc_valid));
      chk($sformatf("%s c%0d win_ready", name, c), 32'(win_ready), 32'(wr));
      chk($sformatf("%s c%0d load_win_reg", name, c), 32'(load_win_reg), 32'(wr));
      chk($sformatf("%s c%0d load_acc", name, c), 32'(load_acc_sum_reg), 32'(c >= w && c <= w + 55));
      chk($sformatf("%s c%0d result_valid", name, c), 32'(result_valid), 32'(rv));
      if (rv) chk($sformatf("%s c%0d result_idx", name, c), 32'(result_idx), 32'(c - (w + 31)));
      chk($sformatf("%s c%0d done", name, c), 32'(done), 32'(c == w + 56));
      chk($sformatf("%s c%0d busy", name, c), 32'(busy), 32'(c <= w + 56));
      if (!dr) begin
        chk($sformatf("%s c%0d row_idle", name, c), 32'(load_row), 0);
        chk($sformatf("%s c%0d grp_idle", name, c), 32'(load_col_group), 0);
      end
      if (exp_load && c == 1) begin
        chk($sformatf("%s first row", name), 32'(load_row), 32'h0001);
        chk($sformatf("%s first grp", name), 32'(load_col_group), 32'h1);
      end
      if (exp_load && c == w - 1) begin
        chk($sformatf("%s last row", name), 32'(load_row), 32'h8000);
        chk($sformatf("%s last grp", name), 32'(load_col_group), 32'h8);
      end
      if (exp_load && stall_len > 0 && c > stall_k && c <= stall_k + stall_len + 1) begin
        chk($sformatf("%s c%0d stall row", name, c), 32'(load_row), 32'h0020);
        chk($sformatf("%s c%0d stall grp", name, c), 32'(load_col_group), 32'h1);
      end
      if (result_valid) nres++;
    end
    chk($sformatf("%s result count", name), 32'(nres), 25);
    desc_valid = 1'b0;
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    start      = 1'b0;
    keep_desc  = 1'b0;
    desc_valid = 1'b0;
    win_valid  = 1'b0;
    rst_n      = 1'b1;
    #1;
    rst_n = 1'b0;
    #2;
    chk_quiet("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_quiet("post reset");

    do_pass("basic",  1'b0, 1'b1, 0, 0, 0, 0);
    do_pass("stall",  1'b0, 1'b1, 20, 5, 0, 0);
    do_pass("poke",   1'b0, 1'b1, 0, 0, 75, 0);
    do_pass("keep",   1'b1, !RELOAD, 0, 0, 0, 0);
    do_pass("abort",  1'b0, 1'b1, 0, 0, 0, 110);
    do_pass("after",  1'b1, 1'b1, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
